// File: rtl/conv_layer_sequencer_pkg.sv
// Shared state encoding, default layer geometry/base addresses and size helpers
// for the conv layer sequencer.
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      LOAD_B,
      LOAD_IN,
      KICK,
      RUN,
      FIN
   } seq_state_t;

   localparam int DEF_IC = 1;
   localparam int DEF_OC = 32;
   localparam int DEF_K  = 3;
   localparam int DEF_IW = 30;
   localparam int DEF_IH = 30;

   localparam logic [15:0] DEF_W_BASE  = 16'h0000;
   localparam logic [15:0] DEF_B_BASE  = 16'h1000;
   localparam logic [15:0] DEF_IN_BASE = 16'h2000;

   function automatic int aw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int n_w(input int oc, input int ic, input int k);
      return oc * ic * k * k;
   endfunction

   function automatic int n_in(input int ic, input int ih, input int iw);
      return ic * ih * iw;
   endfunction

   function automatic int n_out(input int oc, input int k, input int ih, input int iw);
      return oc * (ih - k + 1) * (iw - k + 1);
   endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Command, memory-read, conv-engine and output-buffer signals of the conv layer
// sequencer; master = sequencer side, slave = environment side.
interface conv_layer_sequencer_if #(
   parameter int MEM_AW = 16,
   parameter int IN_AW  = 10,
   parameter int W_AW   = 9,
   parameter int B_AW   = 5,
   parameter int OUT_AW = 15
);
   logic              cmd_start;
   logic              cmd_reload_w;
   logic              cmd_busy;
   logic              cmd_done;
   logic              cmd_error;

   logic              mem_rd_req;
   logic [MEM_AW-1:0] mem_rd_addr;
   logic [31:0]       mem_rd_data;
   logic              mem_rd_valid;

   logic [7:0]        conv_in_data;
   logic              conv_in_we;
   logic [IN_AW-1:0]  conv_in_addr;
   logic [7:0]        conv_w_data;
   logic              conv_w_we;
   logic [W_AW-1:0]   conv_w_addr;
   logic [31:0]       conv_b_data;
   logic              conv_b_we;
   logic [B_AW-1:0]   conv_b_addr;
   logic              conv_start;
   logic              conv_done;
   logic [7:0]        conv_result;
   logic              conv_valid;

   logic [7:0]        out_data;
   logic              out_we;
   logic [OUT_AW-1:0] out_addr;

   modport master (
      input  cmd_start, cmd_reload_w, mem_rd_data, mem_rd_valid,
             conv_done, conv_result, conv_valid,
      output cmd_busy, cmd_done, cmd_error, mem_rd_req, mem_rd_addr,
             conv_in_data, conv_in_we, conv_in_addr,
             conv_w_data, conv_w_we, conv_w_addr,
             conv_b_data, conv_b_we, conv_b_addr, conv_start,
             out_data, out_we, out_addr
   );

   modport slave (
      output cmd_start, cmd_reload_w, mem_rd_data, mem_rd_valid,
             conv_done, conv_result, conv_valid,
      input  cmd_busy, cmd_done, cmd_error, mem_rd_req, mem_rd_addr,
             conv_in_data, conv_in_we, conv_in_addr,
             conv_w_data, conv_w_we, conv_w_addr,
             conv_b_data, conv_b_we, conv_b_addr, conv_start,
             out_data, out_we, out_addr
   );
endinterface

// File: rtl/conv_layer_sequencer_mem_stream_reader.sv
// Reads count consecutive words starting at base, one outstanding request at a
// time; each accepted word is presented as (idx, data, strobe) in its valid cycle.
module mem_stream_reader
   import conv_pkg::*;
#(
   parameter int AW = 16,
   parameter int CW = 10
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          go,
   input  logic [AW-1:0] base,
   input  logic [CW:0]   count,
   output logic          mem_rd_req,
   output logic [AW-1:0] mem_rd_addr,
   input  logic [31:0]   mem_rd_data,
   input  logic          mem_rd_valid,
   output logic [CW-1:0] idx,
   output logic [31:0]   data,
   output logic          strobe,
   output logic          last
);
   logic [CW-1:0] i;

   assign strobe = mem_rd_req & mem_rd_valid;
   assign idx    = i;
   assign data   = mem_rd_data;
   assign last   = ({1'b0, i} == count - 1'b1);

   // req stays high across elements; the address steps as each word is accepted
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_rd_req  <= 1'b0;
         mem_rd_addr <= '0;
         i           <= '0;
      end else if (go) begin
         mem_rd_req  <= 1'b1;
         mem_rd_addr <= base;
         i           <= '0;
      end else if (strobe) begin
         if (last) begin
            mem_rd_req <= 1'b0;
            i          <= '0;
         end else begin
            mem_rd_addr <= mem_rd_addr + 1'b1;
            i           <= i + 1'b1;
         end
      end
   end
endmodule

// File: rtl/conv_layer_sequencer.sv
// Sequences one quantized conv+ReLU layer: load weights, biases and input map,
// kick the engine, capture its results. Optional macro: CONV_SEQ_WEIGHT_CACHE_EN.
module conv_layer_sequencer
   import conv_pkg::*;
#(
   parameter int IC     = DEF_IC,
   parameter int OC     = DEF_OC,
   parameter int K      = DEF_K,
   parameter int IW     = DEF_IW,
   parameter int IH     = DEF_IH,
   parameter int MEM_AW = 16,
   parameter logic [MEM_AW-1:0] W_BASE  = MEM_AW'(DEF_W_BASE),
   parameter logic [MEM_AW-1:0] B_BASE  = MEM_AW'(DEF_B_BASE),
   parameter logic [MEM_AW-1:0] IN_BASE = MEM_AW'(DEF_IN_BASE)
) (
   input logic                   clk,
   input logic                   rstn,
   conv_layer_sequencer_if.master bus
);
   localparam int N_W    = n_w(OC, IC, K);
   localparam int N_B    = OC;
   localparam int N_IN   = n_in(IC, IH, IW);
   localparam int N_OUT  = n_out(OC, K, IH, IW);
   localparam int W_AW   = aw(N_W);
   localparam int B_AW   = aw(N_B);
   localparam int IN_AW  = aw(N_IN);
   localparam int OUT_AW = aw(N_OUT);
   localparam int CNT_W  = max_int(max_int(W_AW, B_AW), IN_AW);
   localparam int OC_W   = aw(N_OUT + 1);

   localparam logic [CNT_W:0]  LEN_W   = (CNT_W + 1)'(N_W);
   localparam logic [CNT_W:0]  LEN_B   = (CNT_W + 1)'(N_B);
   localparam logic [CNT_W:0]  LEN_IN  = (CNT_W + 1)'(N_IN);
   localparam logic [OC_W-1:0] OUT_MAX = OC_W'(N_OUT);

   seq_state_t       state;
   logic             rd_go;
   logic             rd_fire;
   logic             rd_last;
   logic [CNT_W-1:0] rd_idx;
   logic [CNT_W:0]   rd_count;
   logic [MEM_AW-1:0] rd_base;
   logic [31:0]      rd_data;
   logic [OC_W-1:0]  out_cnt;
   logic             conv_done_p1;
`ifdef CONV_SEQ_WEIGHT_CACHE_EN
   logic             w_cached;
`else
   logic             unused_reload_w;
   assign unused_reload_w = bus.cmd_reload_w;
`endif

   always_comb begin
      rd_base  = IN_BASE;
      rd_count = LEN_IN;
      case (state)
         LOAD_W: begin rd_base = W_BASE; rd_count = LEN_W; end
         LOAD_B: begin rd_base = B_BASE; rd_count = LEN_B; end
         default: ;
      endcase
   end

   mem_stream_reader #(.AW(MEM_AW), .CW(CNT_W)) u_reader (
      .clk          (clk),
      .rstn         (rstn),
      .go           (rd_go),
      .base         (rd_base),
      .count        (rd_count),
      .mem_rd_req   (bus.mem_rd_req),
      .mem_rd_addr  (bus.mem_rd_addr),
      .mem_rd_data  (bus.mem_rd_data),
      .mem_rd_valid (bus.mem_rd_valid),
      .idx          (rd_idx),
      .data         (rd_data),
      .strobe       (rd_fire),
      .last         (rd_last)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state             <= IDLE;
         rd_go             <= 1'b0;
         out_cnt           <= '0;
         conv_done_p1      <= 1'b0;
         bus.cmd_busy      <= 1'b0;
         bus.cmd_done      <= 1'b0;
         bus.cmd_error     <= 1'b0;
         bus.conv_in_data  <= '0;
         bus.conv_in_we    <= 1'b0;
         bus.conv_in_addr  <= '0;
         bus.conv_w_data   <= '0;
         bus.conv_w_we     <= 1'b0;
         bus.conv_w_addr   <= '0;
         bus.conv_b_data   <= '0;
         bus.conv_b_we     <= 1'b0;
         bus.conv_b_addr   <= '0;
         bus.conv_start    <= 1'b0;
         bus.out_data      <= '0;
         bus.out_we        <= 1'b0;
         bus.out_addr      <= '0;
`ifdef CONV_SEQ_WEIGHT_CACHE_EN
         w_cached          <= 1'b0;
`endif
      end else begin
         rd_go          <= 1'b0;
         bus.cmd_done   <= 1'b0;
         bus.conv_in_we <= 1'b0;
         bus.conv_w_we  <= 1'b0;
         bus.conv_b_we  <= 1'b0;
         bus.conv_start <= 1'b0;
         bus.out_we     <= 1'b0;
         conv_done_p1   <= bus.conv_done;
         case (state)
            IDLE: if (bus.cmd_start) begin
               bus.cmd_busy  <= 1'b1;
               bus.cmd_error <= 1'b0;
               rd_go         <= 1'b1;
`ifdef CONV_SEQ_WEIGHT_CACHE_EN
               if (w_cached && !bus.cmd_reload_w) state <= LOAD_IN;
               else                               state <= LOAD_W;
               if (bus.cmd_reload_w) w_cached <= 1'b0;
`else
               state <= LOAD_W;
`endif
            end
            LOAD_W: if (rd_fire) begin
               bus.conv_w_we   <= 1'b1;
               bus.conv_w_addr <= rd_idx[W_AW-1:0];
               bus.conv_w_data <= rd_data[7:0];
               if (rd_last) begin state <= LOAD_B; rd_go <= 1'b1; end
            end
            LOAD_B: if (rd_fire) begin
               bus.conv_b_we   <= 1'b1;
               bus.conv_b_addr <= rd_idx[B_AW-1:0];
               bus.conv_b_data <= rd_data;
               if (rd_last) begin state <= LOAD_IN; rd_go <= 1'b1; end
            end
            LOAD_IN: if (rd_fire) begin
               bus.conv_in_we   <= 1'b1;
               bus.conv_in_addr <= rd_idx[IN_AW-1:0];
               bus.conv_in_data <= rd_data[7:0];
               if (rd_last) state <= KICK;
            end
            KICK: begin
               bus.conv_start <= 1'b1;
               out_cnt        <= '0;
               state          <= RUN;
            end
            // results past the output buffer size are dropped and flagged
            RUN: begin
               if (bus.conv_valid) begin
                  if (out_cnt < OUT_MAX) begin
                     bus.out_we   <= 1'b1;
                     bus.out_data <= bus.conv_result;
                     bus.out_addr <= out_cnt[OUT_AW-1:0];
                     out_cnt      <= out_cnt + 1'b1;
                  end else begin
                     bus.cmd_error <= 1'b1;
                  end
               end
               if (bus.conv_done && !conv_done_p1) state <= FIN;
            end
            FIN: begin
               if (out_cnt != OUT_MAX) bus.cmd_error <= 1'b1;
               bus.cmd_done <= 1'b1;
               bus.cmd_busy <= 1'b0;
               state        <= IDLE;
`ifdef CONV_SEQ_WEIGHT_CACHE_EN
               w_cached     <= !bus.cmd_error && (out_cnt == OUT_MAX);
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Randomized bench for conv_layer_sequencer (2x1x3x3 kernels on a 5x5 map) with a
// memory model, an engine model and a queue-based reference of every expected write.
module tb_conv_layer_sequencer;
   import conv_pkg::*;

   localparam int OC = 2, IC = 1, K = 3, IW = 5, IH = 5, MEM_AW = 16;
   localparam logic [15:0] W_BASE = 16'h0000, B_BASE = 16'h1000, IN_BASE = 16'h2000;
   localparam int N_W   = OC * IC * K * K;
   localparam int N_B   = OC;
   localparam int N_IN  = IC * IH * IW;
   localparam int N_OUT = OC * (IH - K + 1) * (IW - K + 1);
   localparam int W_AW = $clog2(N_W), B_AW = $clog2(N_B), IN_AW = $clog2(N_IN), OUT_AW = $clog2(N_OUT);

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   conv_layer_sequencer_if #(.MEM_AW(MEM_AW), .IN_AW(IN_AW), .W_AW(W_AW), .B_AW(B_AW), .OUT_AW(OUT_AW)) bus ();

   conv_layer_sequencer #(.IC(IC), .OC(OC), .K(K), .IW(IW), .IH(IH), .MEM_AW(MEM_AW),
                          .W_BASE(W_BASE), .B_BASE(B_BASE), .IN_BASE(IN_BASE)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   function automatic logic [31:0] mem_val(input logic [15:0] a);
      return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic logic [127:0] outs();
      return 128'({bus.cmd_busy, bus.cmd_done, bus.cmd_error, bus.mem_rd_req, bus.mem_rd_addr,
                   bus.conv_in_data, bus.conv_in_we, bus.conv_in_addr,
                   bus.conv_w_data, bus.conv_w_we, bus.conv_w_addr,
                   bus.conv_b_data, bus.conv_b_we, bus.conv_b_addr, bus.conv_start,
                   bus.out_data, bus.out_we, bus.out_addr});
   endfunction

   // memory model: random latency, logs every accepted address
   int lat_min = 1, lat_max = 1, mcnt = 0, mlat = 1, unstable = 0;
   logic waiting = 1'b0;
   logic [15:0] held_addr;
   logic [15:0] mem_seq[$];

   initial begin
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data  = '0;
      forever begin
         @(negedge clk);
         if (bus.mem_rd_req === 1'b1) begin
            if (waiting && bus.mem_rd_addr !== held_addr) unstable++;
            if (!waiting) begin held_addr = bus.mem_rd_addr; waiting = 1'b1; end
            if (mcnt >= mlat) begin
               bus.mem_rd_valid = 1'b1;
               bus.mem_rd_data  = mem_val(bus.mem_rd_addr);
               mem_seq.push_back(bus.mem_rd_addr);
               mcnt    = 0;
               mlat    = $urandom_range(lat_max, lat_min);
               waiting = 1'b0;
            end else begin
               bus.mem_rd_valid = 1'b0;
               mcnt++;
            end
         end else begin
            bus.mem_rd_valid = 1'b0;
            mcnt    = 0;
            waiting = 1'b0;
         end
      end
   end

   // engine model: eng_n results with random gaps, then a done level of eng_hold cycles
   int eng_n = N_OUT, eng_hold = 1;
   bit eng_coinc = 1'b0;
   logic [7:0] eng_res[$];

   initial begin
      bus.conv_valid  = 1'b0;
      bus.conv_done   = 1'b0;
      bus.conv_result = '0;
      forever begin
         @(negedge clk);
         if (bus.conv_start === 1'b1) begin
            for (int k = 0; k < eng_n; k++) begin
               repeat ($urandom_range(2, 0)) begin @(negedge clk); bus.conv_valid = 1'b0; end
               @(negedge clk);
               bus.conv_valid  = 1'b1;
               bus.conv_result = 8'($urandom);
               eng_res.push_back(bus.conv_result);
               if (eng_coinc && k == eng_n - 1) bus.conv_done = 1'b1;
            end
            @(negedge clk);
            bus.conv_valid = 1'b0;
            bus.conv_done  = 1'b1;
            repeat (eng_hold - 1) @(negedge clk);
            @(negedge clk);
            bus.conv_done = 1'b0;
         end
      end
   end

   // write monitor
   logic [31:0] w_a[$], w_d[$], b_a[$], b_d[$], in_a[$], in_d[$], o_a[$], o_d[$];
   int n_start = 0, n_done = 0;
   logic err_at_done = 1'b0;

   always @(negedge clk) begin
      if (bus.conv_w_we === 1'b1)  begin w_a.push_back(32'(bus.conv_w_addr));  w_d.push_back(32'(bus.conv_w_data));  end
      if (bus.conv_b_we === 1'b1)  begin b_a.push_back(32'(bus.conv_b_addr));  b_d.push_back(bus.conv_b_data);        end
      if (bus.conv_in_we === 1'b1) begin in_a.push_back(32'(bus.conv_in_addr)); in_d.push_back(32'(bus.conv_in_data)); end
      if (bus.out_we === 1'b1)     begin o_a.push_back(32'(bus.out_addr));      o_d.push_back(32'(bus.out_data));     end
      if (bus.conv_start === 1'b1) n_start++;
      if (bus.cmd_done === 1'b1) begin n_done++; err_at_done = bus.cmd_error; end
   end

   task automatic clear_logs();
      w_a.delete(); w_d.delete(); b_a.delete(); b_d.delete();
      in_a.delete(); in_d.delete(); o_a.delete(); o_d.delete();
      mem_seq.delete(); eng_res.delete();
      n_start = 0; n_done = 0; unstable = 0;
   endtask

   task automatic pulse_start(input bit reload);
      @(negedge clk);
      bus.cmd_reload_w = reload;
      bus.cmd_start    = 1'b1;
      @(negedge clk);
      bus.cmd_start    = 1'b0;
   endtask

   task automatic layer_scenario(input string tag, input bit reload, input bit exp_wb, input int n_res,
                                 input int hold, input bit coinc, input bit start_in_run);
      logic [15:0] exp_seq[$];
      logic [31:0] m;
      int n_exp_out;
      int c;
      clear_logs();
      eng_n = n_res; eng_hold = hold; eng_coinc = coinc;
      pulse_start(reload);
      total++;
      if (bus.cmd_busy !== 1'b1 || bus.cmd_error !== 1'b0) begin
         bad++; $display("FAIL %s start_flags: busy=%b error=%b, want busy=1 error=0", tag, bus.cmd_busy, bus.cmd_error);
      end
      if (start_in_run) begin
         for (c = 0; c < 3000 && n_start == 0; c++) @(negedge clk);
         repeat (3) @(negedge clk);
         pulse_start(1'b1);
      end
      for (c = 0; c < 4000 && n_done == 0; c++) @(negedge clk);
      total++;
      if (n_done == 0) begin
         bad++; $display("FAIL %s done_timeout: no cmd_done after %0d cycles", tag, c);
         return;
      end
      repeat (6) @(negedge clk);

      if (exp_wb) begin
         for (int i = 0; i < N_W; i++) exp_seq.push_back(W_BASE + 16'(i));
         for (int i = 0; i < N_B; i++) exp_seq.push_back(B_BASE + 16'(i));
      end
      for (int i = 0; i < N_IN; i++) exp_seq.push_back(IN_BASE + 16'(i));
      total++;
      if (mem_seq.size() != exp_seq.size()) begin
         bad++; $display("FAIL %s mem_reads: got %0d reads want %0d", tag, mem_seq.size(), exp_seq.size());
      end
      for (int i = 0; i < exp_seq.size() && i < mem_seq.size(); i++) begin
         total++;
         if (mem_seq[i] !== exp_seq[i]) begin
            bad++; $display("FAIL %s mem_addr[%0d]: got %h want %h", tag, i, mem_seq[i], exp_seq[i]);
         end
      end
      total++;
      if (unstable != 0) begin bad++; $display("FAIL %s addr_stable: got %0d changes want 0", tag, unstable); end

      total++;
      if (w_a.size() != (exp_wb ? N_W : 0)) begin
         bad++; $display("FAIL %s w_count: got %0d want %0d", tag, w_a.size(), exp_wb ? N_W : 0);
      end
      for (int i = 0; i < w_a.size(); i++) begin
         m = mem_val(W_BASE + 16'(i));
         total++;
         if (w_a[i] !== 32'(i) || w_d[i] !== {24'h0, m[7:0]}) begin
            bad++; $display("FAIL %s w[%0d]: got addr=%0d data=%h want addr=%0d data=%h", tag, i, w_a[i], w_d[i], i, m[7:0]);
         end
      end
      total++;
      if (b_a.size() != (exp_wb ? N_B : 0)) begin
         bad++; $display("FAIL %s b_count: got %0d want %0d", tag, b_a.size(), exp_wb ? N_B : 0);
      end
      for (int i = 0; i < b_a.size(); i++) begin
         m = mem_val(B_BASE + 16'(i));
         total++;
         if (b_a[i] !== 32'(i) || b_d[i] !== m) begin
            bad++; $display("FAIL %s b[%0d]: got addr=%0d data=%h want addr=%0d data=%h", tag, i, b_a[i], b_d[i], i, m);
         end
      end
      total++;
      if (in_a.size() != N_IN) begin bad++; $display("FAIL %s in_count: got %0d want %0d", tag, in_a.size(), N_IN); end
      for (int i = 0; i < in_a.size(); i++) begin
         m = mem_val(IN_BASE + 16'(i));
         total++;
         if (in_a[i] !== 32'(i) || in_d[i] !== {24'h0, m[7:0]}) begin
            bad++; $display("FAIL %s in[%0d]: got addr=%0d data=%h want addr=%0d data=%h", tag, i, in_a[i], in_d[i], i, m[7:0]);
         end
      end

      n_exp_out = (n_res < N_OUT) ? n_res : N_OUT;
      total++;
      if (o_a.size() != n_exp_out) begin bad++; $display("FAIL %s out_count: got %0d want %0d", tag, o_a.size(), n_exp_out); end
      for (int i = 0; i < o_a.size() && i < n_exp_out; i++) begin
         total++;
         if (o_a[i] !== 32'(i) || o_d[i] !== {24'h0, eng_res[i]}) begin
            bad++; $display("FAIL %s out[%0d]: got addr=%0d data=%h want addr=%0d data=%h", tag, i, o_a[i], o_d[i], i, eng_res[i]);
         end
      end
      total++;
      if (n_start != 1) begin bad++; $display("FAIL %s conv_start_count: got %0d want 1", tag, n_start); end
      total++;
      if (n_done != 1) begin bad++; $display("FAIL %s done_count: got %0d want 1", tag, n_done); end
      total++;
      if (err_at_done !== (n_res != N_OUT)) begin
         bad++; $display("FAIL %s error_at_done: got %b want %b", tag, err_at_done, n_res != N_OUT);
      end
      total++;
      if (bus.cmd_busy !== 1'b0) begin bad++; $display("FAIL %s busy_after: got %b want 0", tag, bus.cmd_busy); end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (outs() !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outs()); end
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (outs() !== '0) begin bad++; $display("FAIL idle_outputs: got %h want 0", outs()); end
   endtask

   task automatic test_full_layer();
      lat_min = 1; lat_max = 1;
      layer_scenario("full_layer", 1'b1, 1'b1, N_OUT, 1, 1'b0, 1'b0);
   endtask

   task automatic test_random_latency();
      lat_min = 0; lat_max = 4;
      for (int r = 0; r < 2; r++) layer_scenario("rand_latency", 1'b1, 1'b1, N_OUT, 1, 1'b0, 1'b0);
      lat_min = 1; lat_max = 1;
   endtask

   task automatic test_result_count();
      layer_scenario("short_results", 1'b1, 1'b1, N_OUT - 1, 1, 1'b0, 1'b0);
      layer_scenario("extra_results", 1'b1, 1'b1, N_OUT + 1, 1, 1'b0, 1'b0);
   endtask

   task automatic test_done_hold();
      layer_scenario("done_hold", 1'b1, 1'b1, N_OUT, 2, 1'b1, 1'b1);
   endtask

   task automatic test_reset_mid_load();
      int c;
      clear_logs();
      lat_min = 0; lat_max = 2;
      pulse_start(1'b1);
      for (c = 0; c < 3000 && in_a.size() < 10; c++) @(negedge clk);
      total++;
      if (in_a.size() < 10) begin bad++; $display("FAIL mid_load_reach: got %0d input writes want 10", in_a.size()); end
      rstn = 1'b0;
      #2;
      total++;
      if (outs() !== '0) begin bad++; $display("FAIL mid_load_reset_outputs: got %h want 0", outs()); end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (outs() !== '0) begin bad++; $display("FAIL post_reset_idle: got %h want 0", outs()); end
      layer_scenario("after_reset", 1'b1, 1'b1, N_OUT, 1, 1'b0, 1'b0);
      lat_min = 1; lat_max = 1;
   endtask

   task automatic test_weight_cache();
      layer_scenario("cache_prime", 1'b1, 1'b1, N_OUT, 1, 1'b0, 1'b0);
`ifdef CONV_SEQ_WEIGHT_CACHE_EN
      layer_scenario("cache_hit", 1'b0, 1'b0, N_OUT, 1, 1'b0, 1'b0);
      layer_scenario("cache_forced", 1'b1, 1'b1, N_OUT, 1, 1'b0, 1'b0);
      layer_scenario("cache_err", 1'b0, 1'b0, N_OUT - 1, 1, 1'b0, 1'b0);
      layer_scenario("cache_after_err", 1'b0, 1'b1, N_OUT, 1, 1'b0, 1'b0);
`else
      layer_scenario("no_cache", 1'b0, 1'b1, N_OUT, 1, 1'b0, 1'b0);
`endif
   endtask

   initial begin
      bus.cmd_start    = 1'b0;
      bus.cmd_reload_w = 1'b0;
      rstn = 1'b1;
      #2;
      test_reset();
      test_full_layer();
      test_random_latency();
      test_result_count();
      test_done_hold();
      test_reset_mid_load();
      test_weight_cache();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
- Sequences one quantized conv+ReLU layer end to end.
- Streams weights, biases and the padded input feature map from a shared read-only memory into the conv engine's write ports, then pulses the engine's start.
- Captures every conv_valid result into an output buffer and reports completion or error to the network-level controller.
- Sits between the layer scheduler / DMA memory and one conv engine instance.

Parameters:
- IC, 1, input channels
- OC, 32, output channels
- K, 3, kernel size
- IW, 30, padded input width
- IH, 30, padded input height
- MEM_AW, 16, memory address width
- W_BASE, 16'h0000, weight base address
- B_BASE, 16'h1000, bias base address
- IN_BASE, 16'h2000, input map base address

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- cmd_start  in  1  one-cycle layer start request
- cmd_reload_w  in  1  force weight/bias reload (used only with cache feature)
- cmd_busy  out  1  high from accepted start until cmd_done
- cmd_done  out  1  one-cycle completion pulse
- cmd_error  out  1  sticky result-count mismatch flag, cleared on next accepted start
- mem_rd_req  out  1  read request, held until mem_rd_valid
- mem_rd_addr  out  MEM_AW  read address, stable while req high
- mem_rd_data  in  32  read data
- mem_rd_valid  in  1  data valid / request acknowledge
- conv_in_data, conv_in_we, conv_in_addr  out  8,1,clog2(IC*IH*IW)  feature map write
- conv_w_data, conv_w_we, conv_w_addr  out  8,1,clog2(OC*IC*K*K)  weight write
- conv_b_data, conv_b_we, conv_b_addr  out  32,1,clog2(OC)  bias write
- conv_start  out  1  one-cycle engine start pulse
- conv_done  in  1  engine done level (may stay high >1 cycle)
- conv_result  in  8  engine output
- conv_valid  in  1  engine output strobe
- out_data, out_we, out_addr  out  8,1,clog2(N_OUT)  output buffer write; N_OUT = OC*(IH-K+1)*(IW-K+1)

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; weight-cached flag 0.
- States: IDLE -> LOAD_W -> LOAD_B -> LOAD_IN -> KICK -> RUN -> FIN -> IDLE.
- IDLE: cmd_start accepted -> cmd_busy=1, cmd_error=0, element counter=0, go LOAD_W. cmd_start in any other state is ignored.
- LOAD_x read protocol, one outstanding request:
  - Element i is read from BASE+i, with mem_rd_req held until mem_rd_valid.
  - The cycle after valid, the matching conv_*_we pulses for one cycle with addr=i.
  - Data is mem_rd_data[7:0] for weights/input, and the full 32 bits for bias.
  - The next request is issued in the same cycle as that write.
  - Counts: OC*IC*K*K weights, OC biases, IC*IH*IW input elements.
  - The last write of a phase resets the counter and advances the state.
- KICK: conv_start=1 for exactly one cycle; output counter=0; go RUN.
- RUN:
  - Each conv_valid -> out_we=1 next cycle, with out_data=conv_result and out_addr=output counter; then the counter increments.
  - A rising edge of conv_done (registered previous value 0) -> FIN.
  - conv_valid in the same cycle as the conv_done edge is still captured.
  - Output counter saturates at N_OUT; any extra conv_valid sets cmd_error and is not written.
- FIN:
  - cmd_error |= (output count != N_OUT).
  - cmd_done=1 for one cycle, cmd_busy=0, -> IDLE.
- Latency for one element: req -> valid (memory dependent) + 1 cycle to write.
- Reset mid-operation: immediate return to IDLE with all outputs 0; the engine keeps its own state.

Optional Feature:
- CONV_SEQ_WEIGHT_CACHE_EN defined:
  - A flag is set after a completed layer with no error.
  - A subsequent cmd_start with cmd_reload_w=0 and the flag set skips LOAD_W/LOAD_B and goes directly to LOAD_IN.
  - Flag cleared by reset, by a cmd_error, or by a start with cmd_reload_w=1.
- Undefined: cmd_reload_w is ignored; every start loads weights and biases.

Decomposition:
- Shared package conv_pkg holds:
  - the state encoding enum;
  - derived sizes N_W, N_B, N_IN, N_OUT and their address widths;
  - default base addresses.
- One sub-module, mem_stream_reader: issues the req/valid handshake for a base address and count, and emits (index, data, strobe). It is reused for all three load phases.

Test Plan:
- Parameters for all tests: OC=2, IC=1, K=3, IH=IW=5; memory latency 1 cycle.
- Full layer: cmd_start -> 18 weight writes (addr 0..17), 2 bias writes, 25 input writes, one conv_start pulse, 18 out_we (addr 0..17), one cmd_done, cmd_error=0.
- Variable memory latency of 0-4 random cycles: each mem_rd_addr stays stable until valid; no duplicate or missing conv_*_we; write data equals memory contents.
- Engine model emits 17 results then done -> cmd_error=1 at cmd_done. Emits 19 -> only 18 writes, cmd_error=1.
- conv_done held 2 cycles, and conv_valid coincident with the done edge -> exactly one FIN; the last result is captured; a cmd_start during RUN is ignored.
- rstn asserted mid LOAD_IN -> all outputs 0 within the reset; a new cmd_start reloads from weight 0.
- With CONV_SEQ_WEIGHT_CACHE_EN, a second start with cmd_reload_w=0 -> first memory address is IN_BASE, with zero weight/bias writes.
